// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and
// a ceiling-log2 helper used to size pointers and counters.
package pc_pkg;

   // Source of the next PC value, one code per kind of update.
   typedef enum logic [2:0] {
      INC    = 3'd0,
      HOLD   = 3'd1,
      TARGET = 3'd2,
      RAS    = 3'd3,
      TRAP   = 3'd4
   } pc_sel_e;

   // Ceiling log2. Returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. A push onto a full stack silently overwrites
// the oldest entry. The top entry is read combinationally so that a return
// can redirect the PC in the same cycle. A pop on an empty stack is ignored.
module return_address_stack
   import pc_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int RAS_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top,
   output logic [clog2(RAS_DEPTH):0]  count,
   output logic                       full,
   output logic                       empty
);

   localparam int             PW       = clog2(RAS_DEPTH);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
   localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]    CNT_MAX  = (PW+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0]    r_ptr;        // next free slot; top entry sits just below it
   logic [PW:0]      r_count;
   logic [PW-1:0]    w_top_idx;

   assign w_top_idx = r_ptr - PTR_ONE;
   assign top       = r_mem[w_top_idx];
   assign count     = r_count;
   assign full      = (r_count == CNT_MAX);
   assign empty     = (r_count == '0);

   // Entry storage: contents need no reset, only the pointer and count do.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_ptr] <= push_data;
      end
   end

   // Pointer and occupancy; when full the pointer keeps advancing over the oldest slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (push) begin
         r_ptr <= r_ptr + PTR_ONE;
         if (!full) begin
            r_count <= r_count + CNT_ONE;
         end
      end else if (pop && !empty) begin
         r_ptr   <= r_ptr - PTR_ONE;
         r_count <= r_count - CNT_ONE;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program-counter unit: prioritised next-PC selection (trap,
// stall, return, call, jump, branch, increment), PC register, hardware
// return-address stack and sticky stack-error flags.
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(16'h0004),
   parameter int               RAS_DEPTH    = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       branch,
   input  logic                       jump,
   input  logic                       call,
   input  logic                       ret,
   input  logic                       trap,
   input  logic [WIDTH-1:0]           target,
   input  logic                       clr_flags,
   output logic [WIDTH-1:0]           pc,
   output logic [WIDTH-1:0]           pc_plus1,
   output logic [clog2(RAS_DEPTH):0]  ras_count,
   output logic                       ras_overflow,
   output logic                       ras_underflow
);

   localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_pc;
   logic             r_overflow;
   logic             r_underflow;

   pc_sel_e          w_sel;
   logic [WIDTH-1:0] w_pc_plus1;
   logic [WIDTH-1:0] w_pc_next;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_push_data;
   logic [WIDTH-1:0] w_ras_top;
   logic             w_ras_full;
   logic             w_ras_empty;
   logic             w_set_overflow;
   logic             w_set_underflow;

   assign w_pc_plus1 = r_pc + PC_ONE;

   // Priority encoder: trap > stall > ret > call > jump > branch > increment.
   always_comb begin
      w_sel           = INC;
      w_push          = 1'b0;
      w_pop           = 1'b0;
      w_push_data     = w_pc_plus1;
      w_set_underflow = 1'b0;
      if (trap) begin
         w_sel       = TRAP;
         w_push      = 1'b1;
         w_push_data = r_pc;
      end else if (stall) begin
         w_sel = HOLD;
      end else if (ret) begin
         if (w_ras_empty) begin
            w_sel           = TARGET;
            w_set_underflow = 1'b1;
         end else begin
            w_sel = RAS;
            w_pop = 1'b1;
         end
      end else if (call) begin
         w_sel  = TARGET;
         w_push = 1'b1;
      end else if (jump || branch) begin
         w_sel = TARGET;
      end
   end

   assign w_set_overflow = w_push && w_ras_full;

   // Next-PC multiplexer driven by the select code.
   always_comb begin
      w_pc_next = r_pc;
      case (w_sel)
         INC:     w_pc_next = w_pc_plus1;
         HOLD:    w_pc_next = r_pc;
         TARGET:  w_pc_next = target;
         RAS:     w_pc_next = w_ras_top;
         TRAP:    w_pc_next = TRAP_VECTOR;
         default: w_pc_next = r_pc;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_VECTOR;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // Sticky stack-error flags; a new error wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_set_overflow) begin
            r_overflow <= 1'b1;
         end else if (clr_flags) begin
            r_overflow <= 1'b0;
         end
         if (w_set_underflow) begin
            r_underflow <= 1'b1;
         end else if (clr_flags) begin
            r_underflow <= 1'b0;
         end
      end
   end

   return_address_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_push_data),
      .top       (w_ras_top),
      .count     (ras_count),
      .full      (w_ras_full),
      .empty     (w_ras_empty)
   );

   assign pc            = r_pc;
   assign pc_plus1      = w_pc_plus1;
   assign ras_overflow  = r_overflow;
   assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pc_unit;

   localparam int          WIDTH = 16;
   localparam int          DEPTH = 8;
   localparam logic [15:0] RST_V = 16'h0000;
   localparam logic [15:0] TRP_V = 16'h0004;

   logic        clk;
   logic        reset;
   logic        stall, branch, jump, call, ret, trap, clr_flags;
   logic [15:0] target;
   logic [15:0] pc, pc_plus1;
   logic [3:0]  ras_count;
   logic        ras_overflow, ras_underflow;

   int n_compared;
   int n_mismatched;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_ras[$];
   bit          m_ovf;
   bit          m_unf;

   pc_unit #(
      .WIDTH        (WIDTH),
      .RESET_VECTOR (RST_V),
      .TRAP_VECTOR  (TRP_V),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch        (branch),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .trap          (trap),
      .target        (target),
      .clr_flags     (clr_flags),
      .pc            (pc),
      .pc_plus1      (pc_plus1),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_V;
      m_ras.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   task automatic model_push(input logic [15:0] a, inout bit so);
      if (m_ras.size() == DEPTH) begin
         void'(m_ras.pop_front());
         so = 1;
      end
      m_ras.push_back(a);
   endtask

   task automatic compare_all(input string ctx);
      check({ctx, ".pc"},       32'(pc),            32'(m_pc));
      check({ctx, ".pc_plus1"}, 32'(pc_plus1),      32'(16'(m_pc + 16'd1)));
      check({ctx, ".count"},    32'(ras_count),     32'(m_ras.size()));
      check({ctx, ".ovf"},      32'(ras_overflow),  32'(m_ovf));
      check({ctx, ".unf"},      32'(ras_underflow), 32'(m_unf));
   endtask

   // One clock: drive requests, advance the model, compare after the edge.
   task automatic cycle(input string ctx, input bit st, input bit br, input bit jp,
                        input bit cl, input bit rt, input bit tr,
                        input logic [15:0] tg, input bit clr);
      logic [15:0] n;
      bit so, su;
      stall = st; branch = br; jump = jp; call = cl; ret = rt; trap = tr;
      target = tg; clr_flags = clr;
      n = m_pc; so = 0; su = 0;
      if (tr) begin
         model_push(m_pc, so);
         n = TRP_V;
      end else if (st) begin
         n = m_pc;
      end else if (rt) begin
         if (m_ras.size() > 0) n = m_ras.pop_back();
         else begin n = tg; su = 1; end
      end else if (cl) begin
         model_push(16'(m_pc + 16'd1), so);
         n = tg;
      end else if (jp || br) begin
         n = tg;
      end else begin
         n = 16'(m_pc + 16'd1);
      end
      if (so) m_ovf = 1; else if (clr) m_ovf = 0;
      if (su) m_unf = 1; else if (clr) m_unf = 0;
      m_pc = n;
      @(posedge clk);
      #1;
      compare_all(ctx);
      $display("cyc %-8s st=%0b br=%0b jp=%0b cl=%0b rt=%0b tr=%0b tg=%h clr=%0b -> pc=%h cnt=%0d ovf=%0b unf=%0b",
               ctx, st, br, jp, cl, rt, tr, tg, clr, pc, ras_count, ras_overflow, ras_underflow);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset = 1'b1;
      stall = 0; branch = 0; jump = 0; call = 0; ret = 0; trap = 0;
      clr_flags = 0; target = '0;
      model_reset();
      #12;
      compare_all("reset");
      #1 reset = 1'b0;

      // Reset and wrap
      cycle("jmpffff", 0, 0, 1, 0, 0, 0, 16'hFFFF, 0);
      cycle("wrap",    0, 0, 0, 0, 0, 0, 16'h1234, 0);
      check("wrap_zero", 32'(pc), 32'h0);

      // Redirect priority under stall
      cycle("stallred", 1, 1, 1, 0, 0, 0, 16'h0100, 0);
      check("stall_hold", 32'(pc), 32'h0);
      cycle("redir",    0, 1, 1, 0, 0, 0, 16'h0100, 0);
      check("redir_pc", 32'(pc), 32'h0100);

      // Nested calls
      cycle("j0010", 0, 0, 1, 0, 0, 0, 16'h0010, 0);
      cycle("call1", 0, 0, 0, 1, 0, 0, 16'h0200, 0);
      cycle("call2", 0, 0, 0, 1, 0, 0, 16'h0300, 0);
      check("nest_cnt", 32'(ras_count), 32'd2);
      cycle("ret1",  0, 0, 0, 0, 1, 0, 16'h0000, 0);
      check("ret1_pc", 32'(pc), 32'h0201);
      cycle("ret2",  0, 0, 0, 0, 1, 0, 16'h0000, 0);
      check("ret2_pc", 32'(pc), 32'h0011);
      check("ret2_cnt", 32'(ras_count), 32'd0);

      // Overflow / underflow / clear
      for (int i = 0; i < 9; i++)
         cycle("ocall", 0, 0, 0, 1, 0, 0, 16'(16'h0400 + 16'(i * 16)), 0);
      check("ovf_cnt", 32'(ras_count), 32'd8);
      check("ovf_flag", 32'(ras_overflow), 32'd1);
      for (int i = 0; i < 8; i++)
         cycle("oret", 0, 0, 0, 0, 1, 0, 16'h0000, 0);
      cycle("uret", 0, 0, 0, 0, 1, 0, 16'h0ABC, 0);
      check("unf_pc", 32'(pc), 32'h0ABC);
      check("unf_flag", 32'(ras_underflow), 32'd1);
      cycle("clr", 0, 0, 0, 0, 0, 0, 16'h0000, 1);
      check("clr_ovf", 32'(ras_overflow), 32'd0);
      check("clr_unf", 32'(ras_underflow), 32'd0);

      // Trap beats stall
      cycle("j0050", 0, 0, 1, 0, 0, 0, 16'h0050, 0);
      cycle("trap",  1, 0, 0, 0, 0, 1, 16'h0000, 0);
      check("trap_pc", 32'(pc), 32'(TRP_V));
      check("trap_cnt", 32'(ras_count), 32'd1);
      cycle("tret",  0, 0, 0, 0, 1, 0, 16'h0000, 0);
      check("tret_pc", 32'(pc), 32'h0050);

      // Reset mid-call
      for (int i = 0; i < 3; i++)
         cycle("rcall", 0, 0, 0, 1, 0, 0, 16'(16'h0700 + 16'(i)), 0);
      #2 reset = 1'b1;
      #1;
      check("arst_pc", 32'(pc), 32'(RST_V));
      check("arst_cnt", 32'(ras_count), 32'd0);
      model_reset();
      #2 reset = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rand",
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0,
               16'($urandom),
               $urandom_range(0, 9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
